uart_rx_ctrl: RTL and testbench

Receive-side control unit of the UART RX. Detects the start-bit falling edge and runs the per-frame edge counter (oversampling ticks) and bit counter. Sequences the frame through start, data, optional parity and stop. Drives the enables of the data-sampling, start-check, parity-check, stop-check and deserializer stages, consumes their error outputs, and issues a one-cycle `data_valid` for every clean frame.

---
 rtl/uart_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-edge detect, oversampling edge/bit counters,
// frame sequencing, check/deserializer strobes and registered result pulses.
//
// state  | meaning
// IDLE   | line idle, counters cleared, waiting for RX_IN low
// START  | start bit, glitch check at bit end
// DATA   | DATA_WIDTH data bits, one deser_en per bit end
// PARITY | optional parity bit, sticky error on par_err
// STOP   | stop bit, frame verdict at bit end
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [4:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       deser_en,
  output logic       data_valid,
  output logic       par_error,
  output logic       frm_error
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [3:0] LP_LAST_DATA = 4'(DATA_WIDTH);

  state_t     r_state;
  logic [4:0] r_edge_cnt;
  logic [3:0] r_bit_cnt;
  logic [4:0] r_p_max;
  logic       r_par_en;
  logic       r_sticky;
  logic       r_data_valid;
  logic       r_par_error;
  logic       r_frm_error;

  logic [4:0] w_p_max_in;
  logic       w_bit_end;

  always_comb begin
    w_p_max_in = 5'd7;
    case (Prescale)
      6'd16:   w_p_max_in = 5'd15;
      6'd32:   w_p_max_in = 5'd31;
      default: w_p_max_in = 5'd7;
    endcase
  end

  assign w_bit_end = (r_edge_cnt == r_p_max);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_edge_cnt   <= 5'd0;
      r_bit_cnt    <= 4'd0;
      r_p_max      <= 5'd0;
      r_par_en     <= 1'b0;
      r_sticky     <= 1'b0;
      r_data_valid <= 1'b0;
      r_par_error  <= 1'b0;
      r_frm_error  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_error  <= 1'b0;
      r_frm_error  <= 1'b0;

      if (r_state != S_IDLE) begin
        if (w_bit_end) begin
          r_edge_cnt <= 5'd0;
          r_bit_cnt  <= r_bit_cnt + 4'd1;
        end else begin
          r_edge_cnt <= r_edge_cnt + 5'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (!RX_IN) begin
            r_state    <= S_START;
            r_par_en   <= PAR_EN;
            r_p_max    <= w_p_max_in;
            r_sticky   <= 1'b0;
            r_edge_cnt <= 5'd0;
            r_bit_cnt  <= 4'd0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            if (strt_glitch) begin
              // false start: silently abandon the frame
              r_state    <= S_IDLE;
              r_edge_cnt <= 5'd0;
              r_bit_cnt  <= 4'd0;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_bit_end && (r_bit_cnt == LP_LAST_DATA))
            r_state <= r_par_en ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            if (par_err) begin
              r_sticky    <= 1'b1;
              r_par_error <= 1'b1;
            end
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_state      <= S_IDLE;
            r_edge_cnt   <= 5'd0;
            r_bit_cnt    <= 4'd0;
            r_frm_error  <= stp_err;
            r_data_valid <= !stp_err && !r_sticky;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign edge_cnt    = r_edge_cnt;
  assign bit_cnt     = r_bit_cnt;
  assign dat_samp_en = (r_state != S_IDLE);
  assign strt_chk_en = (r_state == S_START)  && w_bit_end;
  assign deser_en    = (r_state == S_DATA)   && w_bit_end;
  assign par_chk_en  = (r_state == S_PARITY) && w_bit_end;
  assign stp_chk_en  = (r_state == S_STOP)   && w_bit_end;
  assign data_valid  = r_data_valid;
  assign par_error   = r_par_error;
  assign frm_error   = r_frm_error;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames are driven cycle by cycle and every
// strobe/pulse position is recorded, then compared against hand-derived cycles.
module tb_uart_rx_ctrl;
  logic       CLK = 1'b0;
  logic       RST, RX_IN, PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch, par_err, stp_err;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
  logic       data_valid, par_error, frm_error;

  int n_cmp = 0;
  int n_mis = 0;

  int         ec   [0:699];
  int         bc   [0:699];
  logic [7:0] outs [0:699];
  int n_deser, first_deser, last_deser, strt_at, par_at, stp_at;
  int n_dv, first_dv, last_dv, n_pe, pe_at, n_fe, fe_at, n_samp;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .deser_en(deser_en), .data_valid(data_valid), .par_error(par_error),
    .frm_error(frm_error)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives nfr frames (back to back) for len cycles; cycle 0 is the IDLE cycle
  // that sees the falling edge. PAR_EN/Prescale are scrambled mid-frame.
  task automatic run(input logic [5:0] code, input int p, input bit par,
                     input logic [7:0] data, input int nfr, input int len,
                     input int glitch_at, input int parerr_at,
                     input int stperr_at, input int rst_at);
    int fl, loc, bi;
    logic rxv;
    fl = (10 + (par ? 1 : 0)) * p + 1;
    n_deser = 0; first_deser = -1; last_deser = -1; strt_at = -1; par_at = -1;
    stp_at = -1; n_dv = 0; first_dv = -1; last_dv = -1; n_pe = 0; pe_at = -1;
    n_fe = 0; fe_at = -1; n_samp = 0;
    Prescale = code;
    PAR_EN = par;
    for (int c = 0; c < len; c++) begin
      loc = c % fl;
      if (loc == 3) begin
        Prescale = (p == 32) ? 6'd16 : 6'd32;
        PAR_EN = ~par;
      end
      if (loc == fl - 1) begin
        Prescale = code;
        PAR_EN = par;
      end
      rxv = 1'b1;
      if (c < nfr * fl && !(rst_at >= 0 && c > rst_at)) begin
        if (loc == 0) rxv = 1'b0;
        else begin
          bi = (loc - 1) / p;
          if (bi == 0) rxv = 1'b0;
          else if (bi <= 8) rxv = data[bi-1];
          else rxv = 1'b1;
        end
      end
      RX_IN = rxv;
      strt_glitch = (c == glitch_at);
      par_err = (c == parerr_at);
      stp_err = (c == stperr_at);
      RST = (c == rst_at) ? 1'b0 : 1'b1;
      ec[c] = int'(edge_cnt);
      bc[c] = int'(bit_cnt);
      outs[c] = {dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                 deser_en, data_valid, par_error, frm_error};
      if (dat_samp_en) n_samp++;
      if (deser_en) begin
        n_deser++;
        if (first_deser < 0) first_deser = c;
        last_deser = c;
      end
      if (strt_chk_en && strt_at < 0) strt_at = c;
      if (par_chk_en && par_at < 0) par_at = c;
      if (stp_chk_en && stp_at < 0) stp_at = c;
      if (data_valid) begin
        n_dv++;
        if (first_dv < 0) first_dv = c;
        last_dv = c;
      end
      if (par_error) begin n_pe++; if (pe_at < 0) pe_at = c; end
      if (frm_error) begin n_fe++; if (fe_at < 0) fe_at = c; end
      step();
    end
    RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0; RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0; RX_IN = 1'b0; PAR_EN = 1'b1; Prescale = 6'd16;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    step(); step(); step();
    chk("reset_outs", {dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                       deser_en, data_valid, par_error, frm_error}, 0);
    chk("reset_edge", edge_cnt, 0);
    chk("reset_bit", bit_cnt, 0);
    RST = 1'b1;
    idle(3);

    // P=8 via non-standard code 10, no parity, byte 0xA5
    run(6'd10, 8, 1'b0, 8'hA5, 1, 82, -1, -1, -1, -1);
    chk("f1_deser_n", n_deser, 8);
    chk("f1_deser_first", first_deser, 16);
    chk("f1_deser_last", last_deser, 72);
    chk("f1_strt_at", strt_at, 8);
    chk("f1_par_at", par_at, -1);
    chk("f1_stp_at", stp_at, 80);
    chk("f1_dv_n", n_dv, 1);
    chk("f1_dv_at", first_dv, 81);
    chk("f1_err_n", n_pe + n_fe, 0);
    chk("f1_samp_n", n_samp, 80);
    chk("f1_c1_cnt", {ec[1][15:0], bc[1][15:0]}, 0);
    chk("f1_c9_bit", bc[9], 1);
    chk("f1_c9_edge", ec[9], 0);
    chk("f1_c80_bit", bc[80], 9);
    chk("f1_c80_edge", ec[80], 7);
    chk("f1_c81_samp", outs[81][7], 0);
    idle(3);

    // P=16 parity frame with parity error
    run(6'd16, 16, 1'b1, 8'h3C, 1, 178, -1, 160, -1, -1);
    chk("pe_par_at", par_at, 160);
    chk("pe_n", n_pe, 1);
    chk("pe_at", pe_at, 161);
    chk("pe_dv_n", n_dv, 0);
    chk("pe_fe_n", n_fe, 0);
    chk("pe_stp_at", stp_at, 176);
    idle(3);

    // clean P=16 parity frame; sticky flag from previous frame must be gone
    run(6'd16, 16, 1'b1, 8'h5A, 1, 178, -1, -1, -1, -1);
    chk("f2_par_at", par_at, 160);
    chk("f2_stp_at", stp_at, 176);
    chk("f2_dv_n", n_dv, 1);
    chk("f2_dv_at", first_dv, 177);
    chk("f2_pe_n", n_pe, 0);
    chk("f2_deser_n", n_deser, 8);
    chk("f2_deser_last", last_deser, 144);
    chk("f2_c176_bit", bc[176], 10);
    idle(3);

    // stop error
    run(6'd16, 16, 1'b1, 8'h00, 1, 178, -1, -1, 176, -1);
    chk("fe_n", n_fe, 1);
    chk("fe_at", fe_at, 177);
    chk("fe_dv_n", n_dv, 0);
    chk("fe_pe_n", n_pe, 0);
    idle(3);

    // start glitch, then restart with edge at cycle 12
    run(6'd8, 8, 1'b0, 8'hFF, 1, 10, 8, -1, -1, -1);
    chk("gl_strt_at", strt_at, 8);
    chk("gl_deser_n", n_deser, 0);
    chk("gl_pulses", n_dv + n_pe + n_fe, 0);
    chk("gl_c9_outs", outs[9], 0);
    chk("gl_c9_cnt", {ec[9][15:0], bc[9][15:0]}, 0);
    idle(2);
    run(6'd8, 8, 1'b0, 8'h81, 1, 82, -1, -1, -1, -1);
    chk("gl_restart_samp", outs[1][7], 1);
    chk("gl_restart_cnt", {ec[1][15:0], bc[1][15:0]}, 0);
    chk("gl_restart_dv", first_dv, 81);
    idle(3);

    // two back-to-back frames, P=32
    run(6'd32, 32, 1'b0, 8'hC3, 2, 643, -1, -1, -1, -1);
    chk("bb_dv_n", n_dv, 2);
    chk("bb_dv_first", first_dv, 321);
    chk("bb_dv_last", last_dv, 642);
    chk("bb_deser_n", n_deser, 16);
    chk("bb_stp_at", stp_at, 320);
    chk("bb_c321_samp", outs[321][7], 0);
    chk("bb_c322_samp", outs[322][7], 1);
    chk("bb_c322_cnt", {ec[322][15:0], bc[322][15:0]}, 0);
    idle(3);

    // reset at cycle 40 of a P=8 frame
    run(6'd0, 8, 1'b0, 8'hA5, 1, 42, -1, -1, -1, 40);
    chk("rs_c40_samp", outs[40][7], 1);
    chk("rs_c41_outs", outs[41], 0);
    chk("rs_c41_edge", ec[41], 0);
    chk("rs_c41_bit", bc[41], 0);
    idle(3);
    run(6'd0, 8, 1'b1, 8'h96, 1, 90, -1, -1, -1, -1);
    chk("rs_next_par_at", par_at, 80);
    chk("rs_next_stp_at", stp_at, 88);
    chk("rs_next_dv_n", n_dv, 1);
    chk("rs_next_dv_at", first_dv, 89);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
